// File: rtl/fft_butterfly_seq.sv
// Radix-2 DIT butterfly sequencer: X = A + B*W, Y = A - B*W via three compOp transactions.
// Optional FFT_BFLY_UNITY_TWIDDLE_EN skips the multiply when W == 1 + 0j.
module fft_butterfly_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_re,
  input  logic [31:0] a_im,
  input  logic [31:0] b_re,
  input  logic [31:0] b_im,
  input  logic [31:0] w_re,
  input  logic [31:0] w_im,
  output logic [31:0] x_re,
  output logic [31:0] x_im,
  output logic [31:0] y_re,
  output logic [31:0] y_im,
  output logic        busy,
  output logic        ready,
  output logic        err,
  output logic [31:0] cop_re1,
  output logic [31:0] cop_im1,
  output logic [31:0] cop_re2,
  output logic [31:0] cop_im2,
  output logic        cop_op,
  output logic        cop_start,
  input  logic [31:0] cop_re,
  input  logic [31:0] cop_im,
  input  logic        cop_ready
);

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } cplx_t;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_ISSUE, S_MUL_WAIT, S_ADDX_ISSUE,
    S_ADDX_WAIT, S_ADDY_ISSUE, S_ADDY_WAIT, S_DONE
  } state_t;

  localparam int unsigned TMAX = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned CW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

`ifdef FFT_BFLY_UNITY_TWIDDLE_EN
  localparam cplx_t UNITY_W = '{re: 32'h3F80_0000, im: 32'h0000_0000};
`endif

  state_t          state_q, state_d;
  cplx_t           a_q, a_d, b_q, b_d, w_q, w_d, t_q, t_d;
  cplx_t           x_q, x_d, y_q, y_d, op1_q, op1_d, op2_q, op2_d;
  logic            cop_op_q, cop_op_d, cop_start_q, cop_start_d;
  logic            busy_q, busy_d, ready_q, ready_d, err_q, err_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            timeout_hit;
  cplx_t           cop_res;

  assign cop_res     = '{re: cop_re, im: cop_im};
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == CW'(TMAX));

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    w_d         = w_q;
    t_d         = t_q;
    x_d         = x_q;
    y_d         = y_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    cop_op_d    = cop_op_q;
    cop_start_d = 1'b0;
    err_d       = err_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      S_IDLE: if (start) begin
        a_d   = '{re: a_re, im: a_im};
        b_d   = '{re: b_re, im: b_im};
        w_d   = '{re: w_re, im: w_im};
        err_d = 1'b0;
`ifdef FFT_BFLY_UNITY_TWIDDLE_EN
        if (w_d == UNITY_W) begin
          t_d     = b_d;
          state_d = S_ADDX_ISSUE;
        end else begin
          state_d = S_MUL_ISSUE;
        end
`else
        state_d = S_MUL_ISSUE;
`endif
      end
      S_MUL_ISSUE:  state_d = S_MUL_WAIT;
      S_MUL_WAIT:   if (cop_ready) begin t_d = cop_res; state_d = S_ADDX_ISSUE; end
      S_ADDX_ISSUE: state_d = S_ADDX_WAIT;
      S_ADDX_WAIT:  if (cop_ready) begin x_d = cop_res; state_d = S_ADDY_ISSUE; end
      S_ADDY_ISSUE: state_d = S_ADDY_WAIT;
      S_ADDY_WAIT:  if (cop_ready) begin y_d = cop_res; state_d = S_DONE; end
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    // Shared watchdog for all three WAIT states; abort leaves X/Y untouched.
    if ((state_q inside {S_MUL_WAIT, S_ADDX_WAIT, S_ADDY_WAIT}) && !cop_ready) begin
      if (timeout_hit) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end

    // Issue values are registered on entry so they hold through the following WAIT.
    unique case (state_d)
      S_MUL_ISSUE: begin
        cop_start_d = 1'b1;
        cop_op_d    = 1'b0;
        op1_d       = b_d;
        op2_d       = w_d;
        wait_cnt_d  = '0;
      end
      S_ADDX_ISSUE: begin
        cop_start_d = 1'b1;
        cop_op_d    = 1'b1;
        op1_d       = a_d;
        op2_d       = t_d;
        wait_cnt_d  = '0;
      end
      S_ADDY_ISSUE: begin
        cop_start_d = 1'b1;
        cop_op_d    = 1'b1;
        op1_d       = a_d;
        op2_d       = '{re: {~t_d.re[31], t_d.re[30:0]}, im: {~t_d.im[31], t_d.im[30:0]}};
        wait_cnt_d  = '0;
      end
      default: ;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      w_q         <= '0;
      t_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      cop_op_q    <= 1'b0;
      cop_start_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      w_q         <= w_d;
      t_q         <= t_d;
      x_q         <= x_d;
      y_q         <= y_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      cop_op_q    <= cop_op_d;
      cop_start_q <= cop_start_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign x_re      = x_q.re;
  assign x_im      = x_q.im;
  assign y_re      = y_q.re;
  assign y_im      = y_q.im;
  assign cop_re1   = op1_q.re;
  assign cop_im1   = op1_q.im;
  assign cop_re2   = op2_q.re;
  assign cop_im2   = op2_q.im;
  assign cop_op    = cop_op_q;
  assign cop_start = cop_start_q;
  assign busy      = busy_q;
  assign ready     = ready_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fft_butterfly_seq.sv
// Directed bench for fft_butterfly_seq with a table-driven compOp stand-in (fixed latency).
module tb_fft_butterfly_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic [31:0] x_re, x_im, y_re, y_im;
  logic        busy, ready, err;
  logic [31:0] cop_re1, cop_im1, cop_re2, cop_im2;
  logic        cop_op, cop_start;
  logic [31:0] cop_re = '0, cop_im = '0;
  logic        cop_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // compOp stand-in state
  bit          never_ready = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_res = '0;
  int          start_cnt = 0;
  int          ready_cnt = 0;
  logic        ops_log [0:63];

  always #5 clk = ~clk;

  fft_butterfly_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
    .busy(busy), .ready(ready), .err(err),
    .cop_re1(cop_re1), .cop_im1(cop_im1), .cop_re2(cop_re2), .cop_im2(cop_im2),
    .cop_op(cop_op), .cop_start(cop_start),
    .cop_re(cop_re), .cop_im(cop_im), .cop_ready(cop_ready)
  );

  // Hand-computed float32 results for every transaction the directed vectors produce.
  function automatic logic [63:0] cop_calc(input logic op, input logic [31:0] r1, i1, r2, i2);
    case ({op, r1, i1, r2, i2})
      {1'b0, 32'h40400000, 32'h40800000, 32'h00000000, 32'hBF800000}: return {32'h40800000, 32'hC0400000};
      {1'b1, 32'h3F800000, 32'h40000000, 32'h40800000, 32'hC0400000}: return {32'h40A00000, 32'hBF800000};
      {1'b1, 32'h3F800000, 32'h40000000, 32'hC0800000, 32'h40400000}: return {32'hC0400000, 32'h40A00000};
      {1'b0, 32'h40400000, 32'h40800000, 32'h3F800000, 32'h00000000}: return {32'h40400000, 32'h40800000};
      {1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}: return {32'h40800000, 32'h40C00000};
      {1'b1, 32'h3F800000, 32'h40000000, 32'hC0400000, 32'hC0800000}: return {32'hC0000000, 32'hC0000000};
      {1'b0, 32'h00000000, 32'h00000000, 32'h40000000, 32'h40400000}: return {32'h00000000, 32'h00000000};
      {1'b1, 32'h40A00000, 32'hBF800000, 32'h00000000, 32'h00000000}: return {32'h40A00000, 32'hBF800000};
      {1'b1, 32'h40A00000, 32'hBF800000, 32'h80000000, 32'h80000000}: return {32'h40A00000, 32'hBF800000};
      default: return 64'hDEADBEEF_DEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt     <= 0;
      cop_ready <= 1'b0;
      cop_re    <= '0;
      cop_im    <= '0;
    end else begin
      cop_ready <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          cop_ready        <= 1'b1;
          {cop_re, cop_im} <= m_res;
        end
      end else if (cop_start && !never_ready) begin
        m_res <= cop_calc(cop_op, cop_re1, cop_im1, cop_re2, cop_im2);
        m_cnt <= 2;
      end
    end
    if (cop_start) begin
      ops_log[start_cnt & 63] <= cop_op;
      start_cnt <= start_cnt + 1;
    end
    if (ready) ready_cnt <= ready_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller sits on a negedge; returns on the negedge after the accept edge.
  task automatic do_start(input logic [31:0] ar, ai, br, bi, wr, wi);
    a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    {a_re, a_im, b_re, b_im, w_re, w_im} = {6{32'hFFFF_FFFF}};
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_seen"}, 64'(ready), 64'd1);
  endtask

  task automatic check_xy(input string tag, input logic [63:0] ex, input logic [63:0] ey);
    check({tag, "_x"}, {x_re, x_im}, ex);
    check({tag, "_y"}, {y_re, y_im}, ey);
  endtask

  localparam logic [63:0] X1 = {32'h40A00000, 32'hBF800000};
  localparam logic [63:0] Y1 = {32'hC0400000, 32'h40A00000};

  initial begin
    int s0, r0, n;
    rst = 1'b1; start = 1'b0;
    {a_re, a_im, b_re, b_im, w_re, w_im} = '0;
    repeat (3) @(negedge clk);
    check("rst_xy", {x_re, x_im, y_re, y_im} == '0 ? 64'd0 : 64'd1, 64'd0);
    check("rst_flags", 64'({busy, ready, err, cop_start, cop_op}), 64'd0);
    check("rst_cop_ops", 64'({cop_re1, cop_im1, cop_re2, cop_im2} != '0), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic butterfly
    s0 = start_cnt; r0 = ready_cnt;
    do_start(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h00000000, 32'hBF800000);
    check("t1_busy", 64'(busy), 64'd1);
    wait_ready("t1");
    check_xy("t1", X1, Y1);
    @(negedge clk);
    check("t1_ready_pulse", 64'(ready), 64'd0);
    check("t1_busy_done", 64'(busy), 64'd0);
    check("t1_nstart", 64'(start_cnt - s0), 64'd3);
    check("t1_ops", 64'({ops_log[s0], ops_log[s0+1], ops_log[s0+2]}), 64'b011);
    check("t1_nready", 64'(ready_cnt - r0), 64'd1);

    // start while busy is ignored
    s0 = start_cnt; r0 = ready_cnt;
    do_start(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h00000000, 32'hBF800000);
    repeat (2) @(negedge clk);
    a_re = 32'h40E00000; a_im = 32'h41000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready("t2");
    check_xy("t2", X1, Y1);
    repeat (10) @(negedge clk);
    check("t2_nready", 64'(ready_cnt - r0), 64'd1);
    check("t2_nstart", 64'(start_cnt - s0), 64'd3);

    // Asynchronous reset during ADDX_WAIT, then a clean rerun
    s0 = start_cnt; n = 0;
    do_start(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h00000000, 32'hBF800000);
    while (start_cnt != s0 + 2 && n < 100) begin @(negedge clk); n++; end
    check("t3_in_addx_wait", 64'({busy, 32'(start_cnt - s0)}), {31'd0, 1'b1, 32'd2});
    #2 rst = 1'b1;
    #1;
    check("t3_rst_xy", {x_re, x_im} | {y_re, y_im}, 64'd0);
    check("t3_rst_flags", 64'({busy, ready, err, cop_start, cop_op}), 64'd0);
    check("t3_rst_cop", {cop_re1, cop_im1} | {cop_re2, cop_im2}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h00000000, 32'hBF800000);
    wait_ready("t3");
    check_xy("t3", X1, Y1);
    @(negedge clk);

    // Watchdog: compOp never answers
    never_ready = 1'b1; r0 = ready_cnt;
    do_start(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h00000000, 32'hBF800000);
    repeat (16) @(negedge clk);
    check("t4_before_timeout", 64'({busy, err}), 64'b10);
    @(negedge clk);
    check("t4_timeout", 64'({busy, err}), 64'b01);
    repeat (5) @(negedge clk);
    check("t4_err_sticky", 64'(err), 64'd1);
    check("t4_no_ready", 64'(ready_cnt - r0), 64'd0);
    never_ready = 1'b0;
    do_start(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h00000000, 32'hBF800000);
    check("t4_err_cleared", 64'(err), 64'd0);
    wait_ready("t4");
    check_xy("t4", X1, Y1);
    @(negedge clk);

    // Unity twiddle
    s0 = start_cnt;
    do_start(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F800000, 32'h00000000);
    wait_ready("t5");
    check_xy("t5", {32'h40800000, 32'h40C00000}, {32'hC0000000, 32'hC0000000});
    @(negedge clk);
`ifdef FFT_BFLY_UNITY_TWIDDLE_EN
    check("t5_nstart", 64'(start_cnt - s0), 64'd2);
    check("t5_ops", 64'({ops_log[s0], ops_log[s0+1]}), 64'b11);
`else
    check("t5_nstart", 64'(start_cnt - s0), 64'd3);
    check("t5_ops", 64'({ops_log[s0], ops_log[s0+1], ops_log[s0+2]}), 64'b011);
`endif

    // B = 0: X and Y both equal A
    do_start(32'h40A00000, 32'hBF800000, 32'h00000000, 32'h00000000, 32'h40000000, 32'h40400000);
    wait_ready("t6");
    check_xy("t6", {32'h40A00000, 32'hBF800000}, {32'h40A00000, 32'hBF800000});
    @(negedge clk);
    check("t6_ready_pulse", 64'(ready), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
